// File: rtl/yj_basic_pkg.sv
// Shared constants for the quadrature encoder path.
// Gray states are {A, B} levels. Step codes classify one filtered transition.
// The FSM codes cover level acquisition (INIT) and normal counting (RUN).
package yj_basic_pkg;

  typedef logic [1:0] gray_t;
  typedef logic [1:0] step_t;

  localparam gray_t ST00 = 2'b00;
  localparam gray_t ST01 = 2'b01;
  localparam gray_t ST11 = 2'b11;
  localparam gray_t ST10 = 2'b10;

  localparam step_t STEP_NONE = 2'd0;
  localparam step_t STEP_FWD  = 2'd1;
  localparam step_t STEP_REV  = 2'd2;
  localparam step_t STEP_ILL  = 2'd3;

  localparam logic INIT = 1'b0;
  localparam logic RUN  = 1'b1;

  // Successor of a Gray state along the forward sequence 00 -> 01 -> 11 -> 10 -> 00.
  function automatic gray_t gray_fwd(input gray_t cur);
    case (cur)
      ST00:    return ST01;
      ST01:    return ST11;
      ST11:    return ST10;
      default: return ST00;
    endcase
  endfunction

  // Classify the move from prev to next; a two-bit change cannot be resolved.
  function automatic step_t decode_step(input gray_t prev, input gray_t next);
    if (prev == next) begin
      return STEP_NONE;
    end else if ((prev ^ next) == 2'b11) begin
      return STEP_ILL;
    end else if (next == gray_fwd(prev)) begin
      return STEP_FWD;
    end else begin
      return STEP_REV;
    end
  endfunction

endpackage

// File: rtl/yj_quad_encoder_decoder_if.sv
// Bundle between the synchronized encoder pins / control bits and the decoder.
// master: drives channels and control (pins, config, CPU strobes), reads results.
// slave:  the decoder itself.
//   enc_a, enc_b   encoder channels, synchronous to CLK
//   dir_inv        static sign inversion of the count
//   clr            synchronous clear of cnt
//   err_clr        clears the sticky err flag
//   latch_req      captures cnt into latch_val
//   cnt            current signed position
//   latch_val      snapshot of cnt
//   step_pulse     one-cycle pulse per accepted step
//   dir            direction of the last valid step (1 = forward)
//   err            sticky illegal-transition flag
//   ready          initial channel levels acquired
interface yj_quad_encoder_decoder_if #(
  parameter int unsigned CW = 32
);

  logic          enc_a;
  logic          enc_b;
  logic          dir_inv;
  logic          clr;
  logic          err_clr;
  logic          latch_req;
  logic [CW-1:0] cnt;
  logic [CW-1:0] latch_val;
  logic          step_pulse;
  logic          dir;
  logic          err;
  logic          ready;

  modport master (
    output enc_a, enc_b, dir_inv, clr, err_clr, latch_req,
    input  cnt, latch_val, step_pulse, dir, err, ready
  );

  modport slave (
    input  enc_a, enc_b, dir_inv, clr, err_clr, latch_req,
    output cnt, latch_val, step_pulse, dir, err, ready
  );

endinterface

// File: rtl/yj_basic_glitch_filter.sv
// Per-channel glitch filter. A new level is accepted only after FILT
// consecutive samples that differ from the current accepted level.
//   CLK, RSTn  clock and asynchronous active-low reset
//   din        raw channel sample
//   dout       accepted level as it will be registered on this edge
//   stable     din has matched the accepted level for FILT consecutive cycles
module yj_basic_glitch_filter #(
  parameter int unsigned FILT = 4
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic din,
  output logic dout,
  output logic stable
);

  localparam int unsigned   FW       = $clog2(FILT + 1);
  localparam logic [FW-1:0] FiltLast = FW'(FILT - 1);
  localparam logic [FW-1:0] FiltFull = FW'(FILT);

  logic          flt_q, flt_d;
  logic          first_q;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [FW-1:0] scnt_q, scnt_d;

  always_comb begin
    flt_d  = flt_q;
    fcnt_d = fcnt_q;
    scnt_d = scnt_q;
    if (first_q) begin
      // First sample after reset is taken as the accepted level outright.
      flt_d  = din;
      fcnt_d = '0;
      scnt_d = FW'(1);
    end else if (din == flt_q) begin
      fcnt_d = '0;
      if (scnt_q != FiltFull) begin
        scnt_d = scnt_q + FW'(1);
      end
    end else begin
      scnt_d = '0;
      if (fcnt_q == FiltLast) begin
        flt_d  = din;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      flt_q   <= 1'b0;
      first_q <= 1'b1;
      fcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      flt_q   <= flt_d;
      first_q <= 1'b0;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  // Exposing the next level lets the decoder count on the same edge the level is accepted.
  assign dout   = flt_d;
  assign stable = (scnt_q == FiltFull);

endmodule

// File: rtl/yj_quad_encoder_decoder.sv
// Quadrature decoder: filters both channels, decodes Gray transitions at 4x
// resolution and maintains a signed, wrapping position count.
//   CLK, RSTn  clock and asynchronous active-low reset
//   bus        slave side of yj_quad_encoder_decoder_if (channels, control, results)
module yj_quad_encoder_decoder
  import yj_basic_pkg::*;
#(
  parameter int unsigned CW   = 32,
  parameter int unsigned FILT = 4
) (
  input logic                       CLK,
  input logic                       RSTn,
  yj_quad_encoder_decoder_if.slave  bus
);

  logic flt_a, flt_b;
  logic stable_a, stable_b;

  yj_basic_glitch_filter #(
    .FILT (FILT)
  ) u_filt_a (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .din    (bus.enc_a),
    .dout   (flt_a),
    .stable (stable_a)
  );

  yj_basic_glitch_filter #(
    .FILT (FILT)
  ) u_filt_b (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .din    (bus.enc_b),
    .dout   (flt_b),
    .stable (stable_b)
  );

  logic          state_q, state_d;
  gray_t         ab_q, ab_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] latch_q, latch_d;
  logic          pulse_q, pulse_d;
  logic          dir_q, dir_d;
  logic          err_q, err_d;
  step_t         step;

  // ab_q mirrors the registered filter levels, so this is previous vs next level pair.
  assign step = decode_step(ab_q, {flt_a, flt_b});

  always_comb begin
    state_d = state_q;
    ab_d    = {flt_a, flt_b};
    cnt_d   = cnt_q;
    latch_d = latch_q;
    pulse_d = 1'b0;
    dir_d   = dir_q;
    err_d   = err_q;

    if (state_q == INIT && stable_a && stable_b) begin
      state_d = RUN;
    end

    if (bus.err_clr) begin
      err_d = 1'b0;
    end

    if (state_q == RUN) begin
      unique case (step)
        STEP_FWD, STEP_REV: begin
          pulse_d = 1'b1;
          dir_d   = (step == STEP_FWD);
          // dir reports the Gray direction; only the count sign follows dir_inv.
          if ((step == STEP_FWD) ^ bus.dir_inv) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        STEP_ILL: begin
          err_d = 1'b1;
        end
        default: begin
        end
      endcase
    end

    if (bus.clr) begin
      cnt_d = '0;
    end

    // Snapshot always takes the value registered this cycle, before step or clear.
    if (bus.latch_req) begin
      latch_d = cnt_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= INIT;
      ab_q    <= ST00;
      cnt_q   <= '0;
      latch_q <= '0;
      pulse_q <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ab_q    <= ab_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      pulse_q <= pulse_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign bus.cnt        = cnt_q;
  assign bus.latch_val  = latch_q;
  assign bus.step_pulse = pulse_q;
  assign bus.dir        = dir_q;
  assign bus.err        = err_q;
  assign bus.ready      = (state_q == RUN);

endmodule

// File: doc/yj_quad_encoder_decoder.md
# yj_quad_encoder_decoder

Quadrature encoder interface stage that consumes the two encoder channels after the 2-level synchronizer and turns them into a signed position count. Each channel is filtered against glitches, the Gray-code transitions are decoded at 4x resolution, and an up/down counter is maintained. The block also provides a step pulse, a direction flag, a sticky illegal-transition error and a latched snapshot for CPU readout. It sits between the synchronized pin inputs and the register-bus readout logic of the motor-control path.

## Interface
Parameters:
- CW, 32, position counter width (two's complement, signed).
- FILT, 4, consecutive equal samples required to accept a new channel level (2..255).

Ports:
- CLK  in  1  clock.
- RSTn  in  1  reset; asynchronous, active-low; clock CLK.
- enc_a  in  1  channel A, already synchronous to CLK.
- enc_b  in  1  channel B, already synchronous to CLK.
- dir_inv  in  1  static configuration; 1 swaps count sign.
- clr  in  1  synchronous clear of the count.
- err_clr  in  1  clears the sticky err flag.
- latch_req  in  1  captures cnt into latch_val.
- cnt  out  CW  current position.
- latch_val  out  CW  snapshot of cnt.
- step_pulse  out  1  one-cycle pulse per accepted step.
- dir  out  1  direction of the last valid step (1 = forward).
- err  out  1  sticky illegal-transition flag.
- ready  out  1  high once initial channel levels have been acquired.

## Operation
- Filter, per channel: counter fcnt and accepted level flt. Each cycle:
  - raw == flt: fcnt <= 0.
  - raw != flt and fcnt == FILT-1: flt <= raw, fcnt <= 0.
  - otherwise: fcnt++.
  - A pulse shorter than FILT samples is discarded.
- FSM INIT -> RUN:
  - INIT is entered on reset. Both filters run with flt preloaded from the first sample.
  - INIT exits to RUN when both channels have matched flt for FILT consecutive cycles. No counting or error detection happens in INIT.
  - ready = (state == RUN).
- Decode in RUN compares the previous {flt_a, flt_b} with the next value:
  - Forward sequence 00->01->11->10->00 gives +1.
  - The reverse sequence gives -1.
  - dir_inv=1 negates the step.
  - No change: count holds.
  - Both bits changing on one edge: illegal. err <= 1, count unchanged, no step_pulse, dir unchanged.
- Counter:
  - Arithmetic is modulo 2^CW.
  - Wrap-around is silent: max+1 -> min, min-1 -> max.
- Priority on a single edge:
  - clr over step: cnt <= 0, step discarded. step_pulse still fires and dir still updates.
  - err set over err_clr: if both occur in the same cycle, err stays 1.
  - latch_req with a simultaneous step: latch_val gets the pre-update cnt value (the registered value in that cycle).
  - latch_req with clr: latch_val gets the pre-clear value.
- Reset values: cnt=0, latch_val=0, step_pulse=0, dir=0, err=0, ready=0, state=INIT, fcnt=0, flt=0.
- Reset asserted mid-operation returns every register to its reset value immediately; INIT reacquires the levels.

## Timing
- Latency: the raw level changes before edge 0 and stays stable. flt, cnt, dir and step_pulse all update on edge FILT-1, so the latency is FILT cycles.
- Maximum step rate is one accepted step per FILT cycles per channel.
- step_pulse is high for exactly one cycle per valid step.
- clr, err_clr and latch_req act on the edge where they are sampled high. They are level-sampled each cycle with no handshake.
- ready rises no earlier than FILT cycles after reset release.

## Structure
- Shared header/package yj_basic_pkg holds:
  - Gray state constants: ST00, ST01, ST11, ST10.
  - Step encoding: STEP_NONE, STEP_FWD, STEP_REV, STEP_ILL.
  - FSM state codes: INIT, RUN.
- Sub-module yj_basic_glitch_filter (parameter FILT; ports CLK, RSTn, din, dout, stable) is instantiated once per channel. The top level holds the FSM, decoder, counter, latch and flags.

## Test plan
- Reset with enc_a=enc_b=1 held: ready rises after FILT cycles. cnt=0, err=0, and no step_pulse occurs.
- Four forward steps (00->01->11->10->00), each held 10 cycles with FILT=4: cnt=4, dir=1, four step_pulses, each 4 cycles after its input edge. Repeat with dir_inv=1: cnt=-4.
- 3-cycle glitch on enc_a with FILT=4: cnt, flt and step_pulse unchanged.
- 00->11 jump: err=1, cnt unchanged. err_clr and a second illegal jump in the same cycle: err stays 1. err_clr alone: err=0.
- CW=8, cnt=127, one forward step: cnt=-128. From cnt=-128, one reverse step: cnt=127.
- latch_req in the same cycle as a forward step from cnt=5: latch_val=5, cnt=6. clr together with a step: cnt=0 and step_pulse=1. RSTn pulsed mid-count: all outputs 0 and state INIT.
